// File: rtl/hyperbus_cfg_loader_pkg.sv
// Shared types and constants for the hyperbus configuration loader and its register file.
package hyperbus_cfg_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = 4;

  // Word offsets inside the configuration image
  localparam int unsigned LAT_ACC     = 0;
  localparam int unsigned LAT_ADD     = 1;
  localparam int unsigned CS_MAX      = 2;
  localparam int unsigned RW_RECOVERY = 3;
  localparam int unsigned RWDS_DLY    = 4;
  localparam int unsigned ADDR_MAP    = 5;

  // Boot values, also used as the register file reset image
  localparam logic [WORD_W-1:0] DFLT_LAT_ACC     = 32'd6;
  localparam logic [WORD_W-1:0] DFLT_LAT_ADD     = 32'd6;
  localparam logic [WORD_W-1:0] DFLT_CS_MAX      = 32'd665;
  localparam logic [WORD_W-1:0] DFLT_RW_RECOVERY = 32'd6;
  localparam logic [WORD_W-1:0] DFLT_RWDS_DLY    = 32'd2000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_FINISH
  } state_e;

  function automatic int unsigned img_words(int unsigned nr_cs);
    return ADDR_MAP + 2 * nr_cs;
  endfunction

endpackage

// File: rtl/hyperbus_cfg_loader_if.sv
// REG_BUS connection between the loader (master) and the config register slave.
interface hyperbus_cfg_loader_if;
  import hyperbus_cfg_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              write;
  logic [WORD_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              valid;
  logic [WORD_W-1:0] rdata;
  logic              error;
  logic              ready;

  modport master (
    output addr, write, wdata, wstrb, valid,
    input  rdata, error, ready
  );

  modport slave (
    input  addr, write, wdata, wstrb, valid,
    output rdata, error, ready
  );

endinterface

// File: rtl/hyperbus_cfg_loader_timer.sv
// Wait-cycle counter; terminal_o flags that one more stalled cycle reaches the limit.
module hyperbus_cfg_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic terminal_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          term_q, term_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !term_q) begin
      cnt_d = cnt_q + CW'(1);
    end
    term_d = (cnt_d == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      term_q <= (TIMEOUT == 1);
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
    end
  end

  assign terminal_o = term_q;

endmodule

// File: rtl/hyperbus_cfg_loader.sv
// Writes a snapshotted configuration image over REG_BUS and optionally reads it back to compare.
module hyperbus_cfg_loader
  import hyperbus_cfg_pkg::*;
#(
  parameter int unsigned       NR_CS     = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0,
  parameter bit                VERIFY    = 1'b1,
  parameter int unsigned       TIMEOUT   = 64,
  localparam int unsigned      N         = img_words(NR_CS),
  localparam int unsigned      KW        = $clog2(N) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [WORD_W*N-1:0] cfg_image_i,
  hyperbus_cfg_loader_if.master reg_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [KW-1:0]       err_idx_o
);

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [WORD_W*N-1:0] image_q, image_d;
  logic                valid_q, valid_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [KW-1:0]       err_idx_q, err_idx_d;

  logic hs, last, fail, finish;
  logic tmr_en, tmr_term, tmo;

  function automatic logic [WORD_W-1:0] word_at(logic [WORD_W*N-1:0] img, logic [KW-1:0] idx);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == KW'(i)) w = img[WORD_W*i +: WORD_W];
    end
    return w;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_at(logic [KW-1:0] idx);
    return BASE_ADDR + (ADDR_W'(idx) << 2);
  endfunction

  assign tmr_en = valid_q & ~reg_o.ready;
  assign tmo    = tmr_en & tmr_term;

  hyperbus_cfg_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (~tmr_en),
    .en_i       (tmr_en),
    .terminal_o (tmr_term)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    image_d   = image_q;
    valid_d   = valid_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    hs        = valid_q & reg_o.ready;
    last      = (k_q == KW'(N - 1));
    fail      = 1'b0;
    finish    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_WRITE;
          image_d   = cfg_image_i;
          k_d       = '0;
          err_d     = 1'b0;
          err_idx_d = '0;
          valid_d   = 1'b1;
          write_d   = 1'b1;
          addr_d    = addr_at(KW'(0));
          wdata_d   = cfg_image_i[WORD_W-1:0];
          wstrb_d   = '1;
          busy_d    = 1'b1;
        end
      end
      ST_WRITE: begin
        if (tmo) begin
          fail   = 1'b1;
          finish = 1'b1;
        end else if (hs) begin
          if (reg_o.error) begin
            fail   = 1'b1;
            finish = 1'b1;
          end else if (!last) begin
            k_d     = k_q + KW'(1);
            addr_d  = addr_at(k_q + KW'(1));
            wdata_d = word_at(image_q, k_q + KW'(1));
          end else if (VERIFY) begin
            state_d = ST_READ;
            k_d     = '0;
            write_d = 1'b0;
            addr_d  = addr_at(KW'(0));
            wdata_d = '0;
            wstrb_d = '0;
          end else begin
            finish = 1'b1;
          end
        end
      end
      ST_READ: begin
        // A mismatch is recorded but the pass runs on; a bus error aborts it
        if (tmo) begin
          fail   = 1'b1;
          finish = 1'b1;
        end else if (hs) begin
          fail = reg_o.error || (reg_o.rdata != word_at(image_q, k_q));
          if (reg_o.error || last) begin
            finish = 1'b1;
          end else begin
            k_d    = k_q + KW'(1);
            addr_d = addr_at(k_q + KW'(1));
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Only the first failing word is reported
    if (fail && !err_q) begin
      err_d     = 1'b1;
      err_idx_d = k_q;
    end

    if (finish) begin
      state_d = ST_FINISH;
      valid_d = 1'b0;
      write_d = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      wstrb_d = '0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      image_q   <= '0;
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      image_q   <= image_d;
      valid_q   <= valid_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign reg_o.valid = valid_q;
  assign reg_o.write = write_q;
  assign reg_o.addr  = addr_q;
  assign reg_o.wdata = wdata_q;
  assign reg_o.wstrb = wstrb_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_idx_o   = err_idx_q;

endmodule

// File: tb/tb_hyperbus_cfg_loader.sv
// Directed bench for hyperbus_cfg_loader: one write-only and one verifying instance behind a memory slave.
module tb_hyperbus_cfg_loader;
  import hyperbus_cfg_pkg::*;

  localparam int unsigned NR_CS = 2;
  localparam int unsigned N     = img_words(NR_CS);
  localparam int unsigned KW    = $clog2(N) + 1;
  localparam int unsigned TMO   = 64;
  localparam int          BUDGET = 400;

  typedef struct packed {
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start [2];
  logic [32*N-1:0] img;
  logic            busy [2];
  logic            done [2];
  logic            err  [2];
  logic [KW-1:0]   eidx [2];

  logic            v   [2];
  logic            w   [2];
  logic [31:0]     a   [2];
  logic [31:0]     wd  [2];
  logic [3:0]      st  [2];
  logic            rdy [2];
  logic            er  [2];
  logic [31:0]     rd  [2];

  logic [31:0] mem [N];
  xact_t       exp_q [$];
  int          checks = 0;
  int          failures = 0;

  int cfg_err_k, cfg_corrupt_k, cfg_rst_k, cfg_mid_start;
  bit cfg_stall, cfg_never;

  always #5 clk = ~clk;

  hyperbus_cfg_loader_if bus0 ();
  hyperbus_cfg_loader_if bus1 ();

  assign v[0]  = bus0.valid;  assign v[1]  = bus1.valid;
  assign w[0]  = bus0.write;  assign w[1]  = bus1.write;
  assign a[0]  = bus0.addr;   assign a[1]  = bus1.addr;
  assign wd[0] = bus0.wdata;  assign wd[1] = bus1.wdata;
  assign st[0] = bus0.wstrb;  assign st[1] = bus1.wstrb;
  assign bus0.ready = rdy[0]; assign bus1.ready = rdy[1];
  assign bus0.error = er[0];  assign bus1.error = er[1];
  assign bus0.rdata = rd[0];  assign bus1.rdata = rd[1];

  hyperbus_cfg_loader #(.NR_CS(NR_CS), .BASE_ADDR(32'h0), .VERIFY(1'b0), .TIMEOUT(TMO)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .cfg_image_i(img), .reg_o(bus0),
    .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]), .err_idx_o(eidx[0])
  );

  hyperbus_cfg_loader #(.NR_CS(NR_CS), .BASE_ADDR(32'h0), .VERIFY(1'b1), .TIMEOUT(TMO)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .cfg_image_i(img), .reg_o(bus1),
    .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]), .err_idx_o(eidx[1])
  );

  task automatic check(string tag, logic [95:0] obs, logic [95:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] img_word(int i);
    return img[32*i +: 32];
  endfunction

  // Expected bus requests: nw writes, then a full read pass if verifying
  task automatic push(bit verify, int nw);
    xact_t e;
    for (int k = 0; k < nw; k++) begin
      e = '{wr: 1'b1, strb: 4'hF, addr: 32'(4*k), data: img_word(k)};
      exp_q.push_back(e);
    end
    if (verify) begin
      for (int k = 0; k < int'(N); k++) begin
        e = '{wr: 1'b0, strb: 4'h0, addr: 32'(4*k), data: 32'h0};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run(int sel, int exp_n, bit exp_err, int exp_idx, int exp_cyc);
    int    cyc, nx, stall, waits, wi;
    bit    newx, seen_done, aborted;
    xact_t cur, prev, e;
    cyc = 0; nx = 0; stall = 0; waits = 0; newx = 1'b1; seen_done = 1'b0; aborted = 1'b0;
    prev = '0;
    @(negedge clk);
    start[sel] = 1'b1;
    while (!seen_done && !aborted && cyc < BUDGET) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start[sel] = 1'b0; rdy[sel] = 1'b0; er[sel] = 1'b0; rd[sel] = '0;
      if (cyc == cfg_mid_start) start[sel] = 1'b1;
      if (cyc == 1) check("busy_valid_after_start", 96'({busy[sel], v[sel]}), 96'(2'b11));
      if (done[sel]) begin
        seen_done = 1'b1;
        check("busy_low_at_done", 96'({busy[sel], v[sel]}), 96'(0));
      end else if (v[sel]) begin
        cur = '{wr: w[sel], strb: st[sel], addr: a[sel], data: wd[sel]};
        wi  = int'(a[sel] >> 2);
        if (cfg_never) begin
          waits++;
        end else if (w[sel] && wi == cfg_rst_k) begin
          rst = 1'b1; rdy[sel] = 1'b1; aborted = 1'b1;
        end else begin
          if (newx) begin
            stall = cfg_stall ? int'($urandom_range(10, 0)) : 0;
            prev  = cur;
            newx  = 1'b0;
          end else begin
            check("stable_while_stalled", 96'(cur), 96'(prev));
          end
          if (stall > 0) begin
            stall--;
          end else begin
            rdy[sel] = 1'b1; newx = 1'b1; nx++;
            check("request_expected", 96'(exp_q.size() != 0), 96'(1));
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("request", 96'(cur), 96'(e));
            end
            if (wi >= 0 && wi < int'(N)) begin
              if (w[sel]) begin
                er[sel] = (wi == cfg_err_k);
                if (!er[sel]) mem[wi] = wd[sel];
              end else begin
                rd[sel] = mem[wi] ^ ((wi == cfg_corrupt_k) ? 32'h1 : 32'h0);
              end
            end
          end
        end
      end
    end
    check("finished_in_budget", 96'(seen_done | aborted), 96'(1));
    if (aborted) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_mid_xfer", 96'({v[sel], busy[sel], done[sel], err[sel], w[sel], a[sel], st[sel]}), 96'(0));
      rst = 1'b0; rdy[sel] = 1'b0;
      exp_q.delete();
      return;
    end
    check("xfer_count", 96'(nx), 96'(exp_n));
    if (exp_cyc > 0) check("done_cycle", 96'(cyc), 96'(exp_cyc));
    check("err", 96'(err[sel]), 96'(exp_err));
    check("err_idx", 96'(eidx[sel]), 96'(exp_idx));
    check("no_leftover_requests", 96'(exp_q.size()), 96'(0));
    if (cfg_never) check("wait_cycles", 96'(waits), 96'(TMO));
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_after_done", 96'({v[sel], busy[sel], done[sel]}), 96'(0));
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; rdy[s] = 1'b0; er[s] = 1'b0; rd[s] = '0;
    end
    for (int k = 0; k < int'(N); k++) begin
      img[32*k +: 32] = 32'(k + 1);
      mem[k] = '0;
    end
    cfg_err_k = -1; cfg_corrupt_k = -1; cfg_rst_k = -1; cfg_mid_start = -1;
    cfg_stall = 1'b0; cfg_never = 1'b0;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset_state",
            96'({v[s], w[s], a[s], wd[s], st[s], busy[s], done[s], err[s], eidx[s]}), 96'(0));
    end
    rst = 1'b0;

    // Write-only load, ready always high
    push(1'b0, N);
    run(0, N, 1'b0, 0, N + 1);

    // Write plus read-back through an echoing memory
    push(1'b1, N);
    run(1, 2 * N, 1'b0, 0, 2 * N + 1);

    // Read-back mismatch on word 6: pass still completes
    cfg_corrupt_k = 6;
    push(1'b1, N);
    run(1, 2 * N, 1'b1, 6, 2 * N + 1);
    cfg_corrupt_k = -1;

    // Random stalls with a random image
    for (int k = 0; k < int'(N); k++) img[32*k +: 32] = $urandom();
    cfg_stall = 1'b1;
    push(1'b0, N);
    run(0, N, 1'b0, 0, 0);
    push(1'b1, N);
    run(1, 2 * N, 1'b0, 0, 0);
    cfg_stall = 1'b0;

    // Bus error on word 3 aborts the sequence
    cfg_err_k = 3;
    push(1'b0, 4);
    run(0, 4, 1'b1, 3, 5);
    cfg_err_k = -1;

    // Slave never ready: timeout on word 0, mid-run start ignored
    cfg_never = 1'b1; cfg_mid_start = 10;
    run(0, 0, 1'b1, 0, TMO + 1);
    cfg_never = 1'b0; cfg_mid_start = -1;

    // Reset during the write of word 4, then a clean restart
    cfg_rst_k = 4;
    push(1'b0, 4);
    run(0, 0, 1'b0, 0, 0);
    cfg_rst_k = -1;
    push(1'b0, N);
    run(0, N, 1'b0, 0, N + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
